// File: rtl/l2_request_arbiter.sv
// l2_request_arbiter
//   Merges per-core L2 request streams into the single L2 cache request
//   interface. Each core feeds a small FIFO; a round-robin arbiter moves one
//   FIFO head per cycle into a registered output stage that holds under
//   L2 backpressure.
//
// Parameters
//   NUM_PORTS   number of cores, 1..8 (default `NUM_CORES, 4 if not defined)
//   FIFO_DEPTH  entries per port FIFO, power of two, >= 2
//
// Ports
//   clk                    clock, rising edge
//   reset                  asynchronous, active-high reset
//   core_l2req_packet[i]   request from core i (.valid marks presence)
//   core_l2req_ready[i]    FIFO i can accept a push this cycle
//   l2req_packet           registered request to the L2 cache
//   l2req_ready            L2 cache accepts l2req_packet this cycle
//   pc_event_arb_conflict  one-cycle pulse after a grant made while two or
//                          more FIFOs were non-empty; exists only when
//                          L2_ARB_CONFLICT_EVENT_EN is defined

package l2_request_arbiter_pkg;
   typedef struct packed {
      logic        valid;
      logic [1:0]  cmd;
      logic [31:0] addr;
      logic [7:0]  tag;
   } l2req_packet_t;
endpackage

`ifndef NUM_CORES
`define NUM_CORES 4
`endif

module l2_request_arbiter
   import l2_request_arbiter_pkg::*;
#(
   parameter int NUM_PORTS  = `NUM_CORES,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  l2req_packet_t        core_l2req_packet [NUM_PORTS],
   output logic [NUM_PORTS-1:0] core_l2req_ready,
   output l2req_packet_t        l2req_packet,
   input  logic                 l2req_ready
`ifdef L2_ARB_CONFLICT_EVENT_EN
   ,
   output logic                 pc_event_arb_conflict
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

   l2req_packet_t        mem    [NUM_PORTS][FIFO_DEPTH];
   logic [AW-1:0]        rd_ptr [NUM_PORTS];
   logic [AW-1:0]        wr_ptr [NUM_PORTS];
   logic [CW-1:0]        count  [NUM_PORTS];
   logic [PW-1:0]        rr_ptr;
   l2req_packet_t        out_pkt;

   logic [NUM_PORTS-1:0] nonempty;
   logic [NUM_PORTS-1:0] push;
   logic [NUM_PORTS-1:0] pop;
   logic                 loadable;
   logic                 grant_valid;
   logic [PW-1:0]        grant;
   logic [PW-1:0]        rr_next;
   l2req_packet_t        head;
   int                   idx;

   assign l2req_packet = out_pkt;
   assign loadable     = !out_pkt.valid || l2req_ready;

   // Ready depends only on the registered count, so a full FIFO refuses a
   // push even in the cycle it is being popped.
   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         nonempty[i]         = (count[i] != '0);
         core_l2req_ready[i] = !reset && (count[i] != FULL);
         push[i]             = core_l2req_packet[i].valid && core_l2req_ready[i];
      end
   end

   // Scan from the highest offset down so the final assignment is the
   // first non-empty FIFO at or after rr_ptr.
   always_comb begin
      grant_valid = 1'b0;
      grant       = '0;
      idx         = 0;
      for (int off = NUM_PORTS - 1; off >= 0; off--) begin
         idx = int'(rr_ptr) + off;
         if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
         if (nonempty[idx]) begin
            grant_valid = 1'b1;
            grant       = PW'(idx);
         end
      end
      rr_next = (int'(grant) == NUM_PORTS - 1) ? '0 : grant + 1'b1;
      head    = '0;
      pop     = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (int'(grant) == i) begin
            head   = mem[i][rd_ptr[i]];
            pop[i] = loadable && grant_valid;
         end
      end
      head.valid = 1'b1;
   end

   // Storage is not reset: out_pkt only ever loads entries that were written.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_PORTS; i++)
         if (push[i]) mem[i][wr_ptr[i]] <= core_l2req_packet[i];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            count[i]  <= '0;
            rd_ptr[i] <= '0;
            wr_ptr[i] <= '0;
         end
         rr_ptr  <= '0;
         out_pkt <= '0;
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
            if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
            case ({push[i], pop[i]})
               2'b10:   count[i] <= count[i] + 1'b1;
               2'b01:   count[i] <= count[i] - 1'b1;
               default: count[i] <= count[i];
            endcase
         end
         if (loadable) begin
            if (grant_valid) begin
               out_pkt <= head;
               rr_ptr  <= rr_next;
            end else begin
               out_pkt.valid <= 1'b0;
            end
         end
      end
   end

`ifdef L2_ARB_CONFLICT_EVENT_EN
   logic multi;
   // More than one bit set in nonempty.
   assign multi = ((nonempty & (nonempty - 1'b1)) != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) pc_event_arb_conflict <= 1'b0;
      else       pc_event_arb_conflict <= loadable && grant_valid && multi;
   end
`endif

endmodule

// File: tb/tb_l2_request_arbiter.sv
module tb_l2_request_arbiter;
   import l2_request_arbiter_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic l2req_ready = 1'b0;
   always #5 clk = ~clk;

   l2req_packet_t core_pkt [4];
   logic [3:0]    rdy;
   l2req_packet_t out;
   l2req_packet_t core_pkt3 [3];
   logic [2:0]    rdy3;
   l2req_packet_t out3;
`ifdef L2_ARB_CONFLICT_EVENT_EN
   logic conf, conf3;
`endif

   l2_request_arbiter #(.NUM_PORTS(4), .FIFO_DEPTH(4)) u_dut (
      .clk(clk), .reset(reset),
      .core_l2req_packet(core_pkt), .core_l2req_ready(rdy),
      .l2req_packet(out), .l2req_ready(l2req_ready)
`ifdef L2_ARB_CONFLICT_EVENT_EN
      , .pc_event_arb_conflict(conf)
`endif
   );

   l2_request_arbiter #(.NUM_PORTS(3), .FIFO_DEPTH(4)) u_dut3 (
      .clk(clk), .reset(reset),
      .core_l2req_packet(core_pkt3), .core_l2req_ready(rdy3),
      .l2req_packet(out3), .l2req_ready(l2req_ready)
`ifdef L2_ARB_CONFLICT_EVENT_EN
      , .pc_event_arb_conflict(conf3)
`endif
   );

   typedef struct {
      logic [3:0] mask;
      int         n;
      int         ord [4];
   } vec_t;

   vec_t          tbl [8];
   int            checks = 0;
   int            errors = 0;
   int            conf_cnt = 0;
   l2req_packet_t exp_q [$];

   function automatic l2req_packet_t mk(int p, int t);
      l2req_packet_t r;
      r.valid = 1'b1;
      r.cmd   = 2'(p);
      r.addr  = 32'h1000_0000 + 32'(t * 16 + p);
      r.tag   = 8'(t);
      return r;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called once per cycle at the falling edge; scores every transfer.
   task automatic monitor();
      l2req_packet_t e;
`ifdef L2_ARB_CONFLICT_EVENT_EN
      if (conf) conf_cnt++;
`endif
      if (!reset && out.valid && l2req_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pkt: got %h expected none", out);
         end else begin
            e = exp_q.pop_front();
            chk("out_order", out, e);
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic clear_inputs();
      for (int p = 0; p < 4; p++) core_pkt[p] = '0;
      for (int p = 0; p < 3; p++) core_pkt3[p] = '0;
   endtask

   task automatic set_row(int r, logic [3:0] m, int n, int o0, int o1, int o2, int o3);
      tbl[r].mask   = m;
      tbl[r].n      = n;
      tbl[r].ord[0] = o0;
      tbl[r].ord[1] = o1;
      tbl[r].ord[2] = o2;
      tbl[r].ord[3] = o3;
   endtask

   initial begin
      // Expected grant order per row, rr_ptr carried from the previous row
      // (starts at 0 after reset).
      set_row(0, 4'b1111, 4, 0, 1, 2, 3);
      set_row(1, 4'b0100, 1, 2, 0, 0, 0);
      set_row(2, 4'b1011, 3, 3, 0, 1, 0);
      set_row(3, 4'b0110, 2, 2, 1, 0, 0);
      set_row(4, 4'b0001, 1, 0, 0, 0, 0);
      set_row(5, 4'b1001, 2, 3, 0, 0, 0);
      set_row(6, 4'b1110, 3, 1, 2, 3, 0);
      set_row(7, 4'b1000, 1, 3, 0, 0, 0);

      clear_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", rdy, 4'h0);
      chk("rst_out", out, '0);
`ifdef L2_ARB_CONFLICT_EVENT_EN
      chk("rst_conf", conf, 1'b0);
`endif
      @(posedge clk);
      #1;
      reset = 1'b0;
      l2req_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", rdy, 4'hF);
      chk("post_rst_ready3", rdy3, 3'h7);
      @(posedge clk);
      #1;

      // Table: one-cycle pushes on a port mask, drained with L2 always ready.
      for (int r = 0; r < 8; r++) begin
         for (int p = 0; p < 4; p++)
            core_pkt[p] = tbl[r].mask[p] ? mk(p, r * 16 + p) : '0;
         for (int k = 0; k < tbl[r].n; k++)
            exp_q.push_back(mk(tbl[r].ord[k], r * 16 + tbl[r].ord[k]));
         step();
         clear_inputs();
         conf_cnt = 0;
         @(negedge clk);
         chk("lat_cycle1_idle", out.valid, 1'b0);
         monitor();
         @(posedge clk);
         #1;
         @(negedge clk);
         chk("lat_cycle2_valid", out.valid, 1'b1);
         monitor();
         @(posedge clk);
         #1;
         run(tbl[r].n + 2);
         chk("row_drained", exp_q.size(), 0);
`ifdef L2_ARB_CONFLICT_EVENT_EN
         chk("row_conf_cnt", conf_cnt, tbl[r].n - 1);
`endif
      end

      // Four ports, two packets each: P0..P3 twice, 7 conflicting grants.
      conf_cnt = 0;
      for (int p = 0; p < 4; p++) core_pkt[p] = mk(p, 8'h80 + p);
      for (int p = 0; p < 4; p++) exp_q.push_back(mk(p, 8'h80 + p));
      step();
      for (int p = 0; p < 4; p++) core_pkt[p] = mk(p, 8'h90 + p);
      for (int p = 0; p < 4; p++) exp_q.push_back(mk(p, 8'h90 + p));
      step();
      clear_inputs();
      run(10);
      chk("rr8_drained", exp_q.size(), 0);
`ifdef L2_ARB_CONFLICT_EVENT_EN
      chk("rr8_conf_cnt", conf_cnt, 7);
`endif

      // Back-to-back A,B,C on port 0 appear in consecutive cycles N+2..N+4.
      for (int i = 0; i < 3; i++) begin
         core_pkt[0] = mk(0, 8'hA0 + i);
         exp_q.push_back(mk(0, 8'hA0 + i));
         @(negedge clk);
         if (i == 2) chk("b2b_A", out, mk(0, 8'hA0));
         monitor();
         @(posedge clk);
         #1;
      end
      clear_inputs();
      @(negedge clk);
      chk("b2b_B", out, mk(0, 8'hA1));
      monitor();
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("b2b_C", out, mk(0, 8'hA2));
      monitor();
      @(posedge clk);
      #1;
      run(3);
      chk("b2b_drained", exp_q.size(), 0);

      // Backpressure: port 1 streams while L2 is stalled for 10 cycles.
      l2req_ready = 1'b0;
      begin
         int acc;
         acc = 0;
         for (int c = 0; c < 10; c++) begin
            core_pkt[1] = mk(1, 8'hB0 + acc);
            @(negedge clk);
            chk("bp_ready", rdy[1], (c < 5) ? 1'b1 : 1'b0);
            if (c >= 2) chk("bp_hold", out, mk(1, 8'hB0));
            else        chk("bp_empty", out.valid, 1'b0);
            monitor();
            @(posedge clk);
            #1;
            if (c < 5) begin
               exp_q.push_back(mk(1, 8'hB0 + acc));
               acc++;
            end
         end
      end
      clear_inputs();
      l2req_ready = 1'b1;
      run(8);
      chk("bp_drained", exp_q.size(), 0);

      // Full boundary on port 2: push refused in the cycle the full FIFO pops.
      l2req_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         core_pkt[2] = mk(2, 8'hD0 + c);
         @(negedge clk);
         chk("full_fill_ready", rdy[2], 1'b1);
         monitor();
         @(posedge clk);
         #1;
         exp_q.push_back(mk(2, 8'hD0 + c));
      end
      core_pkt[2] = mk(2, 8'hDF);
      l2req_ready = 1'b1;
      @(negedge clk);
      chk("full_refuse", rdy[2], 1'b0);
      monitor();
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("full_accept", rdy[2], 1'b1);
      monitor();
      @(posedge clk);
      #1;
      exp_q.push_back(mk(2, 8'hDF));
      clear_inputs();
      run(8);
      chk("full_drained", exp_q.size(), 0);

      // Pointer wrap on the 3-port instance: grant 2, then port 0 with no gap.
      core_pkt3[2] = mk(2, 8'hC2);
      step();
      core_pkt3[2] = '0;
      core_pkt3[0] = mk(0, 8'hC0);
      step();
      core_pkt3[0] = '0;
      @(negedge clk);
      chk("wrap_grant2", out3, mk(2, 8'hC2));
      monitor();
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("wrap_grant0", out3, mk(0, 8'hC0));
      monitor();
      @(posedge clk);
      #1;

      // Mid-stream reset with three packets in flight.
      l2req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         core_pkt[0] = mk(0, 8'hE0 + i);
         exp_q.push_back(mk(0, 8'hE0 + i));
         step();
      end
      clear_inputs();
      step();
      #3;
      reset = 1'b1;
      #1;
      chk("midrst_valid", out.valid, 1'b0);
      chk("midrst_ready", rdy, 4'h0);
      chk("midrst_valid3", out3.valid, 1'b0);
      exp_q.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      l2req_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 0) chk("midrst_ready_after", rdy, 4'hF);
         chk("no_stale", out.valid, 1'b0);
         monitor();
         @(posedge clk);
         #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
